// File: rtl/mem_exc_unit_pkg.sv
// Shared definitions for the memory-stage exception unit: op encodings, cause codes,
// region attribute bit positions, default address map and record FSM states.
package mem_exc_unit_pkg;

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_LW   = 3'b001;
    localparam logic [2:0] OP_LH   = 3'b010;
    localparam logic [2:0] OP_LB   = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_SH   = 3'b101;
    localparam logic [2:0] OP_SB   = 3'b110;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;

    localparam int ATTR_WORD_ONLY = 0;
    localparam int ATTR_NO_STORE  = 1;
    localparam int ATTR_NO_LOAD   = 2;

    // Legacy peripheral addresses (DM_addr, Time0, Time1, Break_addr) plus the counters
    localparam logic [31:0] DM_ADDR    = 32'h0000_0000;
    localparam logic [31:0] DM_LIMIT   = 32'h0000_2FFF;
    localparam logic [31:0] TIME0_ADDR = 32'h0000_7F00;
    localparam logic [31:0] TIME0_LIM  = 32'h0000_7F0B;
    localparam logic [31:0] TIME1_ADDR = 32'h0000_7F10;
    localparam logic [31:0] TIME1_LIM  = 32'h0000_7F1B;
    localparam logic [31:0] BREAK_ADDR = 32'h0000_7F20;
    localparam logic [31:0] BREAK_LIM  = 32'h0000_7F23;
    localparam logic [31:0] CNT0_ADDR  = 32'h0000_7F08;
    localparam logic [31:0] CNT0_LIM   = 32'h0000_7F0B;
    localparam logic [31:0] CNT1_ADDR  = 32'h0000_7F18;
    localparam logic [31:0] CNT1_LIM   = 32'h0000_7F1B;

    localparam logic [6*32-1:0] DEF_REGION_BASE =
        {DM_ADDR, TIME0_ADDR, TIME1_ADDR, BREAK_ADDR, CNT0_ADDR, CNT1_ADDR};
    localparam logic [6*32-1:0] DEF_REGION_LIMIT =
        {DM_LIMIT, TIME0_LIM, TIME1_LIM, BREAK_LIM, CNT0_LIM, CNT1_LIM};
    localparam logic [6*3-1:0] DEF_REGION_ATTR =
        {3'b000, 3'b001, 3'b001, 3'b000, 3'b010, 3'b010};

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HELD = 1'b1;

endpackage

// File: rtl/mem_exc_unit_region_match.sv
// One address window: inclusive range compare and attribute decode into
// load/store forbid flags (only meaningful when the window is hit).
module mem_region_match
    import mem_exc_unit_pkg::*;
#(
    parameter int             AW    = 32,
    parameter logic [AW-1:0]  BASE  = '0,
    parameter logic [AW-1:0]  LIMIT = '0,
    parameter logic [2:0]     ATTR  = 3'b000
) (
    input  logic [AW-1:0] addr,
    input  logic          sub_word,
    output logic          hit,
    output logic          ld_forbid,
    output logic          st_forbid
);

    logic word_viol;

    assign hit       = (addr >= BASE) && (addr <= LIMIT);
    assign word_viol = ATTR[ATTR_WORD_ONLY] && sub_word;
    assign ld_forbid = hit && (ATTR[ATTR_NO_LOAD]  || word_viol);
    assign st_forbid = hit && (ATTR[ATTR_NO_STORE] || word_viol);

endmodule

// File: rtl/mem_exc_unit.sv
// Registered M-stage AdEL/AdES checker over a configurable region table, with a sticky
// fault record for CP0. Define MEM_EXC_CNT_EN to add saturating per-kind fault counters.
module mem_exc_unit
    import mem_exc_unit_pkg::*;
#(
    parameter int                          AW           = 32,
    parameter int                          NUM_REGIONS  = 6,
    parameter logic [NUM_REGIONS*AW-1:0]   REGION_BASE  = DEF_REGION_BASE,
    parameter logic [NUM_REGIONS*AW-1:0]   REGION_LIMIT = DEF_REGION_LIMIT,
    parameter logic [NUM_REGIONS*3-1:0]    REGION_ATTR  = DEF_REGION_ATTR
`ifdef MEM_EXC_CNT_EN
    ,
    parameter int                          CNT_W        = 16
`endif
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    input  logic [AW-1:0] req_addr,
    input  logic [2:0]    req_op,
    input  logic          stall,
    input  logic          flush,
    output logic          exc_valid,
    output logic          exc_adel,
    output logic          exc_ades,
    output logic          rec_valid,
    output logic [4:0]    rec_cause,
    output logic [AW-1:0] rec_badvaddr,
    output logic          rec_overflow,
    input  logic          rec_ack,
`ifdef MEM_EXC_CNT_EN
    output logic [CNT_W-1:0] cnt_adel,
    output logic [CNT_W-1:0] cnt_ades,
`endif
    output logic [0:0]    dbg_state
);

    logic                   is_load, is_store, sub_word, misalign;
    logic                   any_hit, any_ld_forbid, any_st_forbid;
    logic                   fault_ld, fault_st, update, new_fault;
    logic [NUM_REGIONS-1:0] hit_vec, ld_forbid_vec, st_forbid_vec;
    logic [0:0]             state;

    assign is_load  = (req_op == OP_LW) || (req_op == OP_LH) || (req_op == OP_LB);
    assign is_store = (req_op == OP_SW) || (req_op == OP_SH) || (req_op == OP_SB);
    assign sub_word = (req_op == OP_LH) || (req_op == OP_LB) ||
                      (req_op == OP_SH) || (req_op == OP_SB);

    always_comb begin
        misalign = 1'b0;
        case (req_op)
            OP_LW, OP_SW: misalign = (req_addr[1:0] != 2'b00);
            OP_LH, OP_SH: misalign = req_addr[0];
            default:      misalign = 1'b0;
        endcase
    end

    for (genvar i = 0; i < NUM_REGIONS; i++) begin : g_region
        mem_region_match #(
            .AW    (AW),
            .BASE  (REGION_BASE[i*AW +: AW]),
            .LIMIT (REGION_LIMIT[i*AW +: AW]),
            .ATTR  (REGION_ATTR[i*3 +: 3])
        ) u_match (
            .addr      (req_addr),
            .sub_word  (sub_word),
            .hit       (hit_vec[i]),
            .ld_forbid (ld_forbid_vec[i]),
            .st_forbid (st_forbid_vec[i])
        );
    end

    // Overlapping windows: any forbidding hit wins, no window can grant back access
    assign any_hit       = |hit_vec;
    assign any_ld_forbid = |ld_forbid_vec;
    assign any_st_forbid = |st_forbid_vec;

    assign fault_ld  = req_valid && is_load  && (misalign || !any_hit || any_ld_forbid);
    assign fault_st  = req_valid && is_store && (misalign || !any_hit || any_st_forbid);
    assign update    = !flush && !stall;
    assign new_fault = update && (fault_ld || fault_st);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            exc_valid <= 1'b0;
            exc_adel  <= 1'b0;
            exc_ades  <= 1'b0;
        end else if (flush) begin
            exc_valid <= 1'b0;
            exc_adel  <= 1'b0;
            exc_ades  <= 1'b0;
        end else if (!stall) begin
            exc_valid <= req_valid && (is_load || is_store);
            exc_adel  <= fault_ld;
            exc_ades  <= fault_st;
        end
    end

    // Sticky record: first fault is kept until acked; later ones only flag overflow
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            rec_cause    <= 5'd0;
            rec_badvaddr <= '0;
            rec_overflow <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (new_fault) begin
                        state        <= ST_HELD;
                        rec_cause    <= fault_ld ? EXC_ADEL : EXC_ADES;
                        rec_badvaddr <= req_addr;
                        rec_overflow <= 1'b0;
                    end
                end
                default: begin
                    if (rec_ack) begin
                        rec_overflow <= 1'b0;
                        if (new_fault) begin
                            rec_cause    <= fault_ld ? EXC_ADEL : EXC_ADES;
                            rec_badvaddr <= req_addr;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else if (new_fault) begin
                        rec_overflow <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign rec_valid = (state == ST_HELD);
    assign dbg_state = state;

`ifdef MEM_EXC_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_adel <= '0;
            cnt_ades <= '0;
        end else begin
            if (new_fault && fault_ld && (cnt_adel != {CNT_W{1'b1}}))
                cnt_adel <= cnt_adel + CNT_ONE;
            if (new_fault && fault_st && (cnt_ades != {CNT_W{1'b1}}))
                cnt_ades <= cnt_ades + CNT_ONE;
        end
    end
`endif

endmodule
